// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, oversampled mid-bit sampling, data bits re-inverted,
// with ready/overrun bookkeeping toward the CPU bus.
module uart_receiver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       enable,
    input  logic       UART_RX,
    input  logic       read_ack,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       rx_ready,
    output logic       overrun,
    output logic       frame_error,
    output logic       busy
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, vld_q;
    logic          hi_q;
    logic [DW-1:0] div_q, div_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          ready_q, ready_d, ovr_q, ovr_d;
    logic          rx, tick, fall, half, full, commit, ferr;

    assign rx   = sync_q[1];
    assign tick = div_q == DW'(DIV - 1);
    // hi_q only reflects a genuinely sampled high, so a line held low through reset is no edge
    assign fall = hi_q & ~rx;
    assign half = tick && tcnt_q == TW'(OVERSAMPLE / 2 - 1);
    assign full = tick && tcnt_q == TW'(OVERSAMPLE - 1);

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        commit  = 1'b0;
        ferr    = 1'b0;
        if (!enable) state_d = IDLE;
        else begin
            case (state_q)
                IDLE: if (fall) begin
                    state_d = START;
                    div_d   = '0;
                    tcnt_d  = '0;
                end
                START: if (half) begin
                    state_d = rx ? IDLE : DATA;
                    tcnt_d  = '0;
                    bit_d   = '0;
                end
                DATA: if (full) begin
                    shift_d = {~rx, shift_q[7:1]};
                    tcnt_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                end
                STOP: if (full) begin
                    commit  = rx;
                    ferr    = ~rx;
                    state_d = rx ? IDLE : BRK;
                end
                BRK:     state_d = rx ? IDLE : BRK;
                default: state_d = IDLE;
            endcase
        end
        data_d  = commit ? shift_q : data_q;
        ready_d = commit | (ready_q & ~read_ack);
        ovr_d   = ovr_q | (commit & ready_q & ~read_ack);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            vld_q   <= 2'b00;
            hi_q    <= 1'b0;
            state_q <= IDLE;
            div_q   <= '0;
            tcnt_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], UART_RX};
            vld_q   <= {vld_q[0], 1'b1};
            hi_q    <= vld_q[1] & rx;
            state_q <= state_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RX_DATA     = data_q;
    assign RX_STATUS   = commit;
    assign frame_error = ferr;
    assign rx_ready    = ready_q;
    assign overrun     = ovr_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a frame-level model of the receiver's
// byte/ready/overrun bookkeeping, checked every cycle.
module tb_uart_receiver;
    localparam int BIT = 160;
    // falling line edge to stop-bit sample: 9.5 bit times plus synchronizer/edge pipeline
    localparam int DUE = 1522;
    localparam int WIN = 10;

    typedef struct {
        logic       ferr;
        logic [7:0] b;
        int         due;
    } ev_t;

    logic       sysclk = 1'b0;
    logic       reset, enable, UART_RX, read_ack;
    logic [7:0] RX_DATA;
    logic       RX_STATUS, rx_ready, overrun, frame_error, busy;

    int   vec = 0, err = 0, cyc = 0, n_status = 0, n_ferr = 0, s0 = 0, f0 = 0;
    ev_t  evq[$];
    logic [7:0] m_data = 8'h00, pend_b = 8'h00;
    logic m_ready = 1'b0, m_ovr = 1'b0, pend_v = 1'b0, ack_on_status = 1'b0;

    uart_receiver #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
        .sysclk(sysclk), .reset(reset), .enable(enable), .UART_RX(UART_RX),
        .read_ack(read_ack), .RX_DATA(RX_DATA), .RX_STATUS(RX_STATUS),
        .rx_ready(rx_ready), .overrun(overrun), .frame_error(frame_error), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        ev_t e;
        @(posedge sysclk);
        if (pend_v) begin
            if (m_ready && !read_ack) m_ovr = 1'b1;
            m_ready = 1'b1;
            m_data  = pend_b;
            pend_v  = 1'b0;
        end else if (read_ack) m_ready = 1'b0;
        @(negedge sysclk);
        cyc++;
        if (!reset) begin
            m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; pend_v = 1'b0;
            evq.delete();
        end
        chk("levels", {22'd0, RX_DATA, rx_ready, overrun}, {22'd0, m_data, m_ready, m_ovr});
        if (RX_STATUS && frame_error) chk("pulse_exclusive", 32'd2, 32'd1);
        else if (RX_STATUS || frame_error) begin
            if (RX_STATUS) n_status++; else n_ferr++;
            if (evq.size() == 0 || cyc < evq[0].due - WIN)
                chk("unexpected_pulse", {30'd0, RX_STATUS, frame_error}, 32'd0);
            else begin
                e = evq.pop_front();
                chk("pulse_kind", {31'd0, frame_error}, {31'd0, e.ferr});
                pend_v = RX_STATUS;
                pend_b = e.b;
            end
        end
        if (evq.size() != 0 && cyc > evq[0].due + WIN) begin
            chk("missing_pulse", 32'd0, 32'd1);
            void'(evq.pop_front());
        end
        if (ack_on_status) read_ack = RX_STATUS;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        UART_RX = 1'b0;
        repeat (BIT) step();
        for (int i = 0; i < nbits; i++) begin
            UART_RX = ~b[i];
            repeat (BIT) step();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        evq.push_back('{ferr: !stop, b: b, due: cyc + DUE});
        send_partial(b, 8);
        UART_RX = stop;
        repeat (BIT) step();
        UART_RX = 1'b1 & stop;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; UART_RX = 1'b1; read_ack = 1'b0;
        repeat (5) step();
        chk("rst_data", {24'd0, RX_DATA}, 32'h00);
        chk("rst_flags", {27'd0, RX_STATUS, rx_ready, overrun, frame_error, busy}, 32'd0);
        reset = 1'b1;
        repeat (20) step();

        send_frame(8'hA5, 1'b1);
        repeat (20) step();
        chk("a5_data", {24'd0, RX_DATA}, 32'hA5);
        chk("a5_ready", {31'd0, rx_ready}, 32'd1);
        chk("a5_status_count", n_status, 1);
        read_ack = 1'b1;
        step();
        read_ack = 1'b0;
        chk("ack_clears_ready", {31'd0, rx_ready}, 32'd0);

        s0 = n_status; f0 = n_ferr;
        UART_RX = 1'b0;
        repeat (20) step();
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        repeat (20) step();
        UART_RX = 1'b1;
        repeat (200) step();
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_pulses", n_status - s0 + n_ferr - f0, 0);

        send_frame(8'h3C, 1'b0);
        repeat (200) step();
        chk("brk_busy", {31'd0, busy}, 32'd1);
        chk("ferr_data_kept", {24'd0, RX_DATA}, 32'hA5);
        chk("ferr_count", n_ferr - f0, 1);
        UART_RX = 1'b1;
        repeat (5) step();
        chk("brk_release", {31'd0, busy}, 32'd0);

        send_frame(8'h11, 1'b1);
        repeat (20) step();
        send_frame(8'h22, 1'b1);
        repeat (20) step();
        chk("ovr_data", {24'd0, RX_DATA}, 32'h22);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);

        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();
        chk("ovr_cleared_by_reset", {31'd0, overrun}, 32'd0);
        send_frame(8'h11, 1'b1);
        repeat (20) step();
        ack_on_status = 1'b1;
        send_frame(8'h22, 1'b1);
        ack_on_status = 1'b0;
        repeat (20) step();
        chk("ack_commit_ovr", {31'd0, overrun}, 32'd0);
        chk("ack_commit_ready", {31'd0, rx_ready}, 32'd1);
        chk("ack_commit_data", {24'd0, RX_DATA}, 32'h22);

        s0 = n_status;
        send_partial(8'h96, 4);
        enable = 1'b0;
        step();
        chk("en_abort_idle", {31'd0, busy}, 32'd0);
        UART_RX = 1'b1;
        repeat (20) step();
        enable = 1'b1;
        repeat (20) step();
        chk("en_abort_no_status", n_status - s0, 0);
        send_frame(8'hFF, 1'b1);
        repeat (20) step();
        chk("ff_after_en_abort", {24'd0, RX_DATA}, 32'hFF);

        s0 = n_status;
        send_partial(8'h96, 4);
        reset = 1'b0;
        step();
        chk("rst_abort_idle", {31'd0, busy}, 32'd0);
        UART_RX = 1'b1;
        step();
        reset = 1'b1;
        repeat (20) step();
        chk("rst_abort_no_status", n_status - s0, 0);
        send_frame(8'hFF, 1'b1);
        repeat (20) step();
        chk("ff_after_rst_abort", {24'd0, RX_DATA}, 32'hFF);
        chk("ff_ready", {30'd0, rx_ready, overrun}, 32'd2);

        s0 = n_status;
        reset = 1'b0;
        UART_RX = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        repeat (300) step();
        chk("stuck_low_no_start", {31'd0, busy}, 32'd0);
        UART_RX = 1'b1;
        repeat (20) step();
        chk("stuck_low_no_status", n_status - s0, 0);

        chk("events_drained", evq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
